// File: rtl/hamming_decoder_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Hamming decoder.
// Optional feature macro: HAMMING_SECDED_EN (adds an overall parity bit to the codeword).
package hamming_pkg;

    // Widest syndrome the status struct can carry (covers DATA_W up to 247).
    localparam int MAX_PAR_W = 8;

    // Decoder status delivered alongside every output word.
    typedef struct packed {
        logic                 err_corr;
        logic                 err_uncorr;
        logic [MAX_PAR_W-1:0] err_pos;
    } dec_status_t;

    // True when x is a power of two (these positions hold parity bits).
    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < (data_w + p + 1)) p++;
        return p;
    endfunction

    // Total codeword width, including the overall parity bit when SECDED is built in.
    function automatic int cw_w(input int data_w);
`ifdef HAMMING_SECDED_EN
        return data_w + par_w(data_w) + 1;
`else
        return data_w + par_w(data_w);
`endif
    endfunction

    // Codeword index (0-based) of payload bit idx: idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        bit found;
        cnt   = 0;
        res   = 0;
        found = 1'b0;
        for (int pos = 1; pos <= idx + MAX_PAR_W + 2; pos++) begin
            if (!found && !is_pow2(pos)) begin
                if (cnt == idx) begin
                    res   = pos - 1;
                    found = 1'b1;
                end
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_decoder_pipe_if.sv
// Word-in / word-out bus of the Hamming decoder.
// Optional feature macro: HAMMING_SECDED_EN (widens Entrada by one bit).
//
// Handshake: a word moves across an edge exactly when valid and ready are both
// high at that edge. A source holding valid keeps its payload stable until the
// transfer; ready may be combinational from downstream state; valid never
// depends on ready.
interface hamming_decoder_pipe_if
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4
);
    localparam int PAR_W = par_w(DATA_W);
    localparam int CW_W  = cw_w(DATA_W);

    logic [CW_W-1:0]   Entrada;
    logic              Controle;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] Saida;
    logic              out_valid;
    logic              out_ready;
    logic              err_corr;
    logic              err_uncorr;
    logic [PAR_W-1:0]  err_pos;

    // Environment side: supplies codewords, consumes decoded words.
    modport master (
        output Entrada, Controle, in_valid, out_ready,
        input  in_ready, Saida, out_valid, err_corr, err_uncorr, err_pos
    );

    // Decoder side.
    modport slave (
        input  Entrada, Controle, in_valid, out_ready,
        output in_ready, Saida, out_valid, err_corr, err_uncorr, err_pos
    );
endinterface

// File: rtl/hamming_decoder_pipe_syndrome.sv
// Combinational syndrome and overall-parity check of one codeword.
// Optional feature macro: HAMMING_SECDED_EN (enables the overall parity check).
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [cw_w(DATA_W)-1:0]  cw,
    input  logic                     ctrl,
    output logic [par_w(DATA_W)-1:0] syn,
    output logic                     overall_fail
);
    localparam int PAR_W = par_w(DATA_W);
    localparam int HW_W  = DATA_W + PAR_W;

    // Check k xors every position with bit k set; odd polarity inverts each expectation.
    always_comb begin
        syn = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 0; i < HW_W; i++) begin
                if ((((i + 1) >> k) & 1) != 0) syn[k] = syn[k] ^ cw[i];
            end
            syn[k] = syn[k] ^ ctrl;
        end
    end

`ifdef HAMMING_SECDED_EN
    // Top bit makes the whole word even (ctrl=0) or odd (ctrl=1).
    assign overall_fail = (^cw) ^ ctrl;
`else
    assign overall_fail = 1'b0;
`endif
endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage valid/ready Hamming decoder with single-error correction and
// saturating error counters. Stage 1 holds syndrome + raw payload, stage 2
// holds the corrected payload and status.
// Optional feature macro: HAMMING_SECDED_EN (overall parity bit, double-error detection).
module hamming_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    hamming_decoder_pipe_if.slave bus,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt
);
    localparam int PAR_W = par_w(DATA_W);
    localparam int HW_W  = DATA_W + PAR_W;

    logic [PAR_W-1:0]  syn;
    logic              of_fail;
    logic [DATA_W-1:0] raw_data;

    logic              v1;
    logic [PAR_W-1:0]  s1_syn;
    logic [DATA_W-1:0] s1_data;
    logic              s1_of;

    logic              v2;
    logic [DATA_W-1:0] s2_data;
    dec_status_t       s2_st;

    logic              adv1;
    logic              adv2;
    logic              out_hs;
    logic              in_range;
    logic              flip_en;
    logic [DATA_W-1:0] corr_data;
    dec_status_t       nxt_st;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .cw           (bus.Entrada),
        .ctrl         (bus.Controle),
        .syn          (syn),
        .overall_fail (of_fail)
    );

    // A stage advances when empty or when the stage after it empties this cycle.
    assign adv2          = !v2 || bus.out_ready;
    assign adv1          = !v1 || adv2;
    assign out_hs        = v2 && bus.out_ready;
    assign bus.in_ready  = adv1 && !Reset;
    assign bus.out_valid = v2;
    assign bus.Saida     = s2_data;
    assign bus.err_corr   = s2_st.err_corr;
    assign bus.err_uncorr = s2_st.err_uncorr;
    assign bus.err_pos    = s2_st.err_pos[PAR_W-1:0];

    // Payload extraction and conditional bit flip, one slice per payload bit.
    for (genvar j = 0; j < DATA_W; j++) begin : g_bits
        localparam int               DP      = data_pos(j);
        localparam logic [PAR_W-1:0] SYN_HIT = PAR_W'(DP + 1);
        assign raw_data[j]  = bus.Entrada[DP];
        assign corr_data[j] = s1_data[j] ^ (flip_en && (s1_syn == SYN_HIT));
    end

    // Stage 1: capture syndrome, raw payload and overall-parity result.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            v1      <= 1'b0;
            s1_syn  <= '0;
            s1_data <= '0;
            s1_of   <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_syn  <= syn;
                s1_data <= raw_data;
                s1_of   <= of_fail;
            end
        end
    end

    // Classify the stage-1 word and decide whether a bit gets flipped.
    always_comb begin
        flip_en  = 1'b0;
        nxt_st   = '0;
        in_range = (s1_syn != '0) && (int'({1'b0, s1_syn}) <= HW_W);
`ifdef HAMMING_SECDED_EN
        if (s1_syn == '0) begin
            // Only the overall bit can be wrong here; payload is clean.
            nxt_st.err_corr = s1_of;
        end else if (!s1_of) begin
            // Non-zero syndrome with good overall parity: two bits flipped.
            nxt_st.err_uncorr = 1'b1;
        end else if (in_range) begin
            flip_en         = 1'b1;
            nxt_st.err_corr = 1'b1;
            nxt_st.err_pos  = MAX_PAR_W'(s1_syn);
        end else begin
            nxt_st.err_uncorr = 1'b1;
        end
`else
        if (in_range) begin
            flip_en         = 1'b1;
            nxt_st.err_corr = 1'b1;
            nxt_st.err_pos  = MAX_PAR_W'(s1_syn);
        end else if (s1_syn != '0) begin
            // Syndrome points past the end of a shortened code.
            nxt_st.err_uncorr = 1'b1;
        end
`endif
    end

    // Stage 2: register corrected payload and status; held while stalled.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            v2      <= 1'b0;
            s2_data <= '0;
            s2_st   <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_data <= corr_data;
                s2_st   <= nxt_st;
            end
        end
    end

    // Corrected-word counter: counts delivered words, saturates, clear has priority.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            corr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt <= '0;
        end else if (out_hs && s2_st.err_corr && (corr_cnt != '1)) begin
            corr_cnt <= corr_cnt + CNT_W'(1);
        end
    end

    // Uncorrectable-word counter, same rules as above.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            uncorr_cnt <= '0;
        end else if (out_hs && s2_st.err_uncorr && (uncorr_cnt != '1)) begin
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

    // Upper err_pos bits of the shared status type are never driven non-zero.
    logic unused_bits;
    if (PAR_W < MAX_PAR_W) begin : g_unused
        assign unused_bits = ^{s2_st.err_pos[MAX_PAR_W-1:PAR_W], s1_of};
    end else begin : g_unused_full
        assign unused_bits = s1_of;
    end
endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Scoreboard bench for hamming_decoder_pipe: directed words, backpressure,
// counter saturation/clear, mid-stream reset and a randomized stream.
// Optional feature macro: HAMMING_SECDED_EN (bench follows the same build).
module tb_hamming_decoder_pipe;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    function automatic int calc_par_w(input int d);
        int p;
        p = 1;
        while ((1 << p) < (d + p + 1)) p++;
        return p;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int HW_W  = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
    localparam int CW_W  = HW_W + 1;
`else
    localparam int CW_W  = HW_W;
`endif
    localparam int W = DATA_W + 2 + PAR_W;

    logic             clk = 1'b0;
    logic             Reset;
    logic             clr_cnt;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
    logic             rand_rdy;

    logic [W-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;
    int m_corr     = 0;
    int m_uncorr   = 0;

    hamming_decoder_pipe_if #(.DATA_W(DATA_W)) bus ();

    hamming_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Syndrome = xor of the positions of all 1 bits; odd polarity inverts every check.
    function automatic logic [W-1:0] ref_decode(input logic [CW_W-1:0] cw, input logic ctrl);
        int s;
        int flip;
        int n;
        bit corr;
        bit uncorr;
        bit of;
        logic [CW_W-1:0]   fixed;
        logic [DATA_W-1:0] d;
        s = 0;
        for (int p = 1; p <= HW_W; p++) if (cw[p-1]) s = s ^ p;
        if (ctrl) s = s ^ ((1 << PAR_W) - 1);
        of = (^cw) ^ ctrl;
        corr = 0; uncorr = 0; flip = 0;
`ifdef HAMMING_SECDED_EN
        if (s == 0) corr = of;
        else if (!of) uncorr = 1;
        else if (s <= HW_W) begin corr = 1; flip = s; end
        else uncorr = 1;
`else
        if (of) corr = 0;
        if (s != 0 && s <= HW_W) begin corr = 1; flip = s; end
        else if (s != 0) uncorr = 1;
`endif
        fixed = cw;
        if (flip != 0) fixed[flip-1] = ~fixed[flip-1];
        n = 0;
        d = '0;
        for (int p = 1; p <= HW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[n] = fixed[p-1];
                n++;
            end
        end
        return {d, corr, uncorr, PAR_W'(flip)};
    endfunction

    // Builds a valid codeword for payload d under polarity ctrl.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d, input logic ctrl);
        logic [CW_W-1:0] cw;
        int x;
        int n;
        int tgt;
        cw = '0; x = 0; n = 0;
        for (int p = 1; p <= HW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[n];
                if (d[n]) x = x ^ p;
                n++;
            end
        end
        tgt = ctrl ? ((1 << PAR_W) - 1) : 0;
        for (int k = 0; k < PAR_W; k++) begin
            if ((((x ^ tgt) >> k) & 1) != 0) cw[(1 << k) - 1] = 1'b1;
        end
`ifdef HAMMING_SECDED_EN
        cw[CW_W-1] = (^cw[HW_W-1:0]) ^ ctrl;
`endif
        return cw;
    endfunction

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents one word and waits (bounded) for acceptance; called at posedge+1.
    task automatic send(input logic [CW_W-1:0] cw, input logic ctrl, input logic [W-1:0] exp);
        bit ok;
        ok = 0;
        bus.Entrada  = cw;
        bus.Controle = ctrl;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no in_ready, expected acceptance within 200 cycles");
        end
    endtask

    task automatic send_model(input logic [CW_W-1:0] cw, input logic ctrl);
        send(cw, ctrl, ref_decode(cw, ctrl));
    endtask

    // Random payload with exactly one flipped codeword bit.
    task automatic send_one_err();
        logic [CW_W-1:0] cw;
        logic c;
        c  = 1'($urandom_range(0, 1));
        cw = encode(DATA_W'($urandom), c);
        cw[$urandom_range(0, CW_W - 1)] ^= 1'b1;
        send_model(cw, c);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
    endtask

    task automatic reset_mid();
        @(posedge clk); #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_corr_cnt", 64'(corr_cnt), 64'd0);
        check("mid_rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("mid_rst_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        forever begin
            @(negedge clk);
            if (Reset) begin
                m_corr   = 0;
                m_uncorr = 0;
            end else begin
                check("corr_cnt", 64'(corr_cnt), 64'(m_corr));
                check("uncorr_cnt", 64'(uncorr_cnt), 64'(m_uncorr));
                e = '0;
                if (bus.out_valid && bus.out_ready) begin
                    got = {bus.Saida, bus.err_corr, bus.err_uncorr, bus.err_pos};
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got %0h, expected no word", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 64'(got), 64'(e));
                    end
                end
                if (clr_cnt) begin
                    m_corr   = 0;
                    m_uncorr = 0;
                end else if (bus.out_valid && bus.out_ready) begin
                    if (e[PAR_W+1] && m_corr < (1 << CNT_W) - 1) m_corr++;
                    if (e[PAR_W] && m_uncorr < (1 << CNT_W) - 1) m_uncorr++;
                end
            end
        end
    end

    // Random consumer stalls during the randomized phase.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CW_W-1:0] cw;
        logic c;
        int acc;
        Reset = 1'b1;
        clr_cnt = 1'b0;
        rand_rdy = 1'b0;
        bus.Entrada = '0;
        bus.Controle = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_saida", 64'(bus.Saida), 64'd0);
        check("rst_err_corr", 64'(bus.err_corr), 64'd0);
        check("rst_corr_cnt", 64'(corr_cnt), 64'd0);
        check("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed words with hand-derived results: {Saida, err_corr, err_uncorr, err_pos}.
`ifdef HAMMING_SECDED_EN
        send(8'b01010101, 1'b0, {4'b1011, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        check("latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        send(8'b01000111, 1'b0, {4'b1001, 1'b0, 1'b1, 3'd0});
        send(8'b01000101, 1'b0, {4'b1011, 1'b1, 1'b0, 3'd5});
        send(8'b11010101, 1'b0, {4'b1011, 1'b1, 1'b0, 3'd0});
`else
        send(7'b1010101, 1'b0, {4'b1011, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        check("latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        send(7'b1000101, 1'b0, {4'b1011, 1'b1, 1'b0, 3'd5});
        send(7'b1011110, 1'b1, {4'b1011, 1'b0, 1'b0, 3'd0});
        send(7'b1011110, 1'b0, {4'b0011, 1'b1, 1'b0, 3'd7});
`endif
        drain();

        // Backpressure: two words fill the pipe, the third must wait.
        bus.out_ready = 1'b0;
        acc = 0;
        send_model(encode(4'b0110, 1'b0), 1'b0);
        acc++;
        send_model(encode(4'b1001, 1'b1), 1'b1);
        acc++;
        cw = encode(4'b1111, 1'b0);
        bus.Entrada  = cw;
        bus.Controle = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc++;
            check("stall_out_held", 64'({bus.Saida, bus.err_corr, bus.err_uncorr, bus.err_pos}),
                  64'(exp_q[0]));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("stall_accept_count", 64'(acc), 64'd2);
        bus.out_ready = 1'b1;
        send_model(cw, 1'b0);
        drain();

        // Saturation and clear-over-increment.
        pulse_clr();
        for (int i = 0; i < 5; i++) send_one_err();
        drain();
        check("corr_cnt_saturated", 64'(corr_cnt), 64'd3);
        send_one_err();
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("corr_cnt_clr_wins", 64'(corr_cnt), 64'd0);
        drain();

        // Mid-stream reset with counters non-zero and words in flight.
        send_one_err();
        send_one_err();
        drain();
        bus.out_ready = 1'b0;
        send_one_err();
        send_one_err();
        reset_mid();
        bus.out_ready = 1'b1;

        // Randomized stream: 0..2 flipped bits, random polarity, idle gaps and stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            c  = 1'($urandom_range(0, 1));
            cw = encode(DATA_W'($urandom), c);
            case ($urandom_range(0, 2))
                1: cw[$urandom_range(0, CW_W - 1)] ^= 1'b1;
                2: begin
                    int a;
                    int b;
                    a = $urandom_range(0, CW_W - 1);
                    b = (a + $urandom_range(1, CW_W - 1)) % CW_W;
                    cw[a] ^= 1'b1;
                    cw[b] ^= 1'b1;
                end
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) pulse_clr();
            send_model(cw, c);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_pipe.md
Name: hamming_decoder_pipe

Overview:
Parametrised successor to the 7-bit-in / 4-bit-out Hamming decoder. Decodes a DATA_W-bit payload from a Hamming codeword with single-error correction, through a 2-stage valid/ready pipeline. Per-word parity polarity select (Controle) and saturating error counters. Sits between the received-word source and the data consumer in the decoder datapath.

Parameters:
DATA_W, 4, payload width; any value ≥1 (shortened codes allowed).
CNT_W, 8, width of the saturating error counters.
PAR_W, derived localparam, smallest p with 2^p ≥ DATA_W+p+1 (3 for DATA_W=4).
CW_W, derived localparam, DATA_W+PAR_W, plus 1 when HAMMING_SECDED_EN is defined.

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Entrada  in  CW_W  codeword.
Controle  in  1  parity polarity for this word: 0 even, 1 odd.
in_valid  in  1  Entrada/Controle valid.
in_ready  out  1  block accepts the word this cycle.
Saida  out  DATA_W  decoded (corrected) payload.
out_valid  out  1  Saida and status valid.
out_ready  in  1  consumer accepts.
err_corr  out  1  single error corrected in this word.
err_uncorr  out  1  uncorrectable word.
err_pos  out  PAR_W  syndrome (Hamming position of the corrected bit; 0 if none).
clr_cnt  in  1  synchronous counter clear.
corr_cnt  out  CNT_W  saturating count of err_corr words.
uncorr_cnt  out  CNT_W  saturating count of err_uncorr words.

Behaviour:
- Bit map: Entrada[i] = Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Data bits are taken in ascending non-power-of-two position order; Saida[0] = position 3.
- Parity checks:
  - Check k covers every position with bit k set.
  - With Controle=1, every check's expected value is inverted.
  - Syndrome = vector of failed checks.
- Stage 1 registers syndrome, raw data and Controle-derived flags.
- Stage 2 applies the correction and registers Saida and status.
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid, when not stalled.
- Throughput: 1 word/cycle.
- Handshake:
  - A stage advances when it is empty, or the downstream stage advances in the same cycle.
  - in_ready = stage 1 can advance; it is combinational from the stage state and out_ready.
  - The output holds stable while out_valid & !out_ready.
  - Order is preserved; no drops, no duplicates.
- Syndrome outcomes (SEC only):
  - syndrome 0: clean.
  - syndrome 1..DATA_W+PAR_W: flip that position, err_corr=1.
  - syndrome > DATA_W+PAR_W (shortened codes): err_uncorr=1, data passed uncorrected.
- Counters:
  - Increment on the output handshake (out_valid & out_ready) only.
  - Saturate at all-ones.
  - clr_cnt wins over a same-cycle increment.
- Reset (async, any time, including mid-stream):
  - Pipeline valids, Saida, status flags and counters all go to 0.
  - in_ready=0 while Reset is high; in_ready=1 the first cycle after release.
  - In-flight words are discarded.

Optional Feature:
HAMMING_SECDED_EN.
- Defined:
  - Entrada[CW_W-1] is an overall parity bit over all other bits, polarity per Controle.
  - syndrome 0, overall ok: clean.
  - syndrome ≠0, overall fail: correct the bit, err_corr=1.
  - syndrome 0, overall fail: overall-bit error; data clean, err_corr=1, err_pos=0.
  - syndrome ≠0, overall ok: double error; err_uncorr=1, data uncorrected.
- Not defined: no overall bit, pure SEC as above; err_uncorr is asserted only for out-of-range syndromes (always 0 for DATA_W=4).

Decomposition:
- Package hamming_pkg holds:
  - Function par_w(data_w) and function is_pow2.
  - Function data_pos(idx) (codeword index of data bit idx).
  - Typedef dec_status_t {err_corr, err_uncorr, err_pos}.
- Sub-module hamming_syndrome: combinational syndrome plus overall parity, given codeword and Controle. Instantiated in stage 1.

Test Plan:
- Clean word, DATA_W=4, Controle=0: Entrada=7'b1010101 → after 2 cycles Saida=4'b1011, err_corr=0, err_pos=0.
- Single error: Entrada=7'b1000101 (position 5 flipped) → Saida=4'b1011, err_corr=1, err_pos=5, corr_cnt=1.
- Odd polarity: Entrada=7'b1011110 with Controle=1 → Saida=4'b1011, no error; the same word with Controle=0 → err_corr=1.
- Backpressure: out_ready=0, 3 words offered → exactly 2 accepted, in_ready=0; on out_ready=1, all 3 emerge in order with no duplicates.
- Saturation and clear: CNT_W=2, 5 corrected words → corr_cnt=3; clr_cnt pulse coinciding with a 6th corrected word → corr_cnt=0.
- SECDED (macro defined): 8'b01010101 → clean Saida=4'b1011; 8'b01000111 (bits 4 and 1 flipped) → err_uncorr=1, Saida=4'b1001. Reset asserted mid-stream → out_valid and counters go to 0 immediately.
